// File: rtl/vga_pkg.sv
// VGA mode description shared by the timing generator and its comparator.
// Holds the two supported modes and helpers that derive the last pixel/line index.
package vga_pkg;

    localparam int FLD_W = 12;

    typedef struct packed {
        logic [FLD_W-1:0] h_active;
        logic [FLD_W-1:0] h_fp;
        logic [FLD_W-1:0] h_sync;
        logic [FLD_W-1:0] h_bp;
        logic [FLD_W-1:0] v_active;
        logic [FLD_W-1:0] v_fp;
        logic [FLD_W-1:0] v_sync;
        logic [FLD_W-1:0] v_bp;
        logic             h_pol;   // 1 = sync pulse is high
        logic             v_pol;
    } vga_mode_t;

    localparam vga_mode_t MODE_1024x768 = '{
        h_active: 12'd1024, h_fp: 12'd24, h_sync: 12'd136, h_bp: 12'd160,
        v_active: 12'd768,  v_fp: 12'd3,  v_sync: 12'd6,   v_bp: 12'd29,
        h_pol: 1'b0, v_pol: 1'b0
    };

    localparam vga_mode_t MODE_800x600 = '{
        h_active: 12'd800, h_fp: 12'd40, h_sync: 12'd128, h_bp: 12'd88,
        v_active: 12'd600, v_fp: 12'd1,  v_sync: 12'd4,   v_bp: 12'd23,
        h_pol: 1'b1, v_pol: 1'b1
    };

    function automatic logic [FLD_W-1:0] h_last(input vga_mode_t m);
        return m.h_active + m.h_fp + m.h_sync + m.h_bp - 12'd1;
    endfunction

    function automatic logic [FLD_W-1:0] v_last(input vga_mode_t m);
        return m.v_active + m.v_fp + m.v_sync + m.v_bp - 12'd1;
    endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// Combinational comparator for one axis: maps a count and the mode's
// active/front-porch/sync widths and polarity to blank, sync and display-enable.
module vga_sync_gen #(
    parameter int W = 11
) (
    input  logic [W-1:0] count,
    input  logic [W-1:0] active,
    input  logic [W-1:0] fp,
    input  logic [W-1:0] sync_len,
    input  logic         pol,
    output logic         blnk,
    output logic         pulse,
    output logic         de
);

    logic [W:0] win_start;
    logic [W:0] win_end;

    // One extra bit so the window end cannot wrap for any legal mode.
    always_comb begin
        win_start = {1'b0, active} + {1'b0, fp};
        win_end   = win_start + {1'b0, sync_len};
        blnk      = (count >= active);
        pulse     = (({1'b0, count} >= win_start) && ({1'b0, count} < win_end)) ? pol : ~pol;
        de        = ~blnk;
    end

endmodule

// File: rtl/vga_timing_multi.sv
// Two-mode VGA timing generator (1024x768 / 800x600) with frame-aligned mode switching.
// Define VGA_TIMING_FRAME_CNT_EN to build the frame counter; otherwise frame_cnt is tied to 0.
module vga_timing_multi
    import vga_pkg::*;
#(
    parameter int CNT_W = 11,
    parameter int FRM_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_sel,
    output logic             mode_act,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             de,
    output logic             frame_start,
    output logic [FRM_W-1:0] frame_cnt
);

    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             mode_nxt;
    logic             frame_wrap;
    logic             h_blnk_n, h_sync_n, h_de_n;
    logic             v_blnk_n, v_sync_n, v_de_n;

    // Next position; mode_sel is only looked at on the last pixel of a frame.
    always_comb begin
        h_nxt      = hcount + CNT_W'(1);
        v_nxt      = vcount;
        mode_nxt   = mode_act;
        frame_wrap = 1'b0;
        if (hcount == CNT_W'(mode_act ? h_last(MODE_800x600) : h_last(MODE_1024x768))) begin
            h_nxt = '0;
            if (vcount == CNT_W'(mode_act ? v_last(MODE_800x600) : v_last(MODE_1024x768))) begin
                v_nxt      = '0;
                mode_nxt   = mode_sel;
                frame_wrap = 1'b1;
            end else begin
                v_nxt = vcount + CNT_W'(1);
            end
        end
    end

    // Decode the next position so every registered output lines up with hcount/vcount.
    vga_sync_gen #(.W(CNT_W)) u_hgen (
        .count    (h_nxt),
        .active   (CNT_W'(mode_nxt ? MODE_800x600.h_active : MODE_1024x768.h_active)),
        .fp       (CNT_W'(mode_nxt ? MODE_800x600.h_fp     : MODE_1024x768.h_fp)),
        .sync_len (CNT_W'(mode_nxt ? MODE_800x600.h_sync   : MODE_1024x768.h_sync)),
        .pol      (mode_nxt ? MODE_800x600.h_pol : MODE_1024x768.h_pol),
        .blnk     (h_blnk_n),
        .pulse    (h_sync_n),
        .de       (h_de_n)
    );

    vga_sync_gen #(.W(CNT_W)) u_vgen (
        .count    (v_nxt),
        .active   (CNT_W'(mode_nxt ? MODE_800x600.v_active : MODE_1024x768.v_active)),
        .fp       (CNT_W'(mode_nxt ? MODE_800x600.v_fp     : MODE_1024x768.v_fp)),
        .sync_len (CNT_W'(mode_nxt ? MODE_800x600.v_sync   : MODE_1024x768.v_sync)),
        .pol      (mode_nxt ? MODE_800x600.v_pol : MODE_1024x768.v_pol),
        .blnk     (v_blnk_n),
        .pulse    (v_sync_n),
        .de       (v_de_n)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            mode_act    <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            de          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            mode_act    <= mode_nxt;
            hsync       <= h_sync_n;
            vsync       <= v_sync_n;
            hblnk       <= h_blnk_n;
            vblnk       <= v_blnk_n;
            de          <= h_de_n & v_de_n;
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + FRM_W'(1);
        end
    end
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_multi.sv
// Bench for vga_timing_multi: frame-position model checked every cycle, plus
// directed scenarios with hand-computed timing figures.
module tb_vga_timing_multi;

    localparam int CNT_W = 11;
    localparam int FRM_W = 16;
`ifdef VGA_TIMING_FRAME_CNT_EN
    localparam int FCNT_EN = 1;
`else
    localparam int FCNT_EN = 0;
`endif

    logic             clk, rst, mode_sel;
    logic             mode_act, hsync, vsync, hblnk, vblnk, de, frame_start;
    logic [CNT_W-1:0] hcount, vcount;
    logic [FRM_W-1:0] frame_cnt;

    int n_vec = 0;
    int n_err = 0;
    int n_fs  = 0;

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    vga_timing_multi #(.CNT_W(CNT_W), .FRM_W(FRM_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_sel    (mode_sel),
        .mode_act    (mode_act),
        .hcount      (hcount),
        .vcount      (vcount),
        .hsync       (hsync),
        .vsync       (vsync),
        .hblnk       (hblnk),
        .vblnk       (vblnk),
        .de          (de),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    // mode table, index 0 = 1024x768, 1 = 800x600
    int h_act[2] = '{1024, 800};
    int h_fp[2]  = '{24, 40};
    int h_sw[2]  = '{136, 128};
    int h_tot[2] = '{1344, 1056};
    int v_act[2] = '{768, 600};
    int v_fp[2]  = '{3, 1};
    int v_sw[2]  = '{6, 4};
    int v_tot[2] = '{806, 628};
    int pol[2]   = '{0, 1};

    // model state: pixel index within the current frame
    int m_k, m_mode, m_fcnt;
    int m_fs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic int sync_lvl(input int c, input int a, input int f, input int s, input int p);
        if (c >= a + f && c < a + f + s) return p;
        return 1 - p;
    endfunction

    // scoreboard: advance the model on each edge, compare just after it
    initial begin
        int h, v, fc;
        m_k = 0; m_mode = 0; m_fcnt = 0; m_fs = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_k = 0; m_mode = 0; m_fcnt = 0; m_fs = 0;
            end else if (m_k == h_tot[m_mode] * v_tot[m_mode] - 1) begin
                m_k = 0; m_mode = int'(mode_sel); m_fcnt++; m_fs = 1;
            end else begin
                m_k++; m_fs = 0;
            end
            #1;
            h  = m_k % h_tot[m_mode];
            v  = m_k / h_tot[m_mode];
            fc = (FCNT_EN != 0) ? (m_fcnt % (1 << FRM_W)) : 0;
            chk("hcount", hcount, h);
            chk("vcount", vcount, v);
            chk("mode_act", mode_act, m_mode);
            chk("hblnk", hblnk, (h >= h_act[m_mode]) ? 1 : 0);
            chk("vblnk", vblnk, (v >= v_act[m_mode]) ? 1 : 0);
            chk("de", de, (h < h_act[m_mode] && v < v_act[m_mode]) ? 1 : 0);
            chk("hsync", hsync, sync_lvl(h, h_act[m_mode], h_fp[m_mode], h_sw[m_mode], pol[m_mode]));
            chk("vsync", vsync, sync_lvl(v, v_act[m_mode], v_fp[m_mode], v_sw[m_mode], pol[m_mode]));
            chk("frame_start", frame_start, m_fs);
            chk("frame_cnt", frame_cnt, fc);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_start === 1'b1) n_fs++;
        end
    end

    task automatic wait_v(input int target, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (vcount == CNT_W'(target)) break;
        end
        chk("wait_vcount", vcount, target);
    endtask

    // driver / directed scenarios
    initial begin
        int n, hs_n, hs_start, hb_n, vs_n, vs_start, max_v, max_h, bad;
        rst = 1'b1;
        mode_sel = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_hcount", hcount, 0);
        chk("rst_vcount", vcount, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_de", de, 1);
        chk("rst_frame_start", frame_start, 0);
        rst = 1'b0;

        // first mode-0 frame: sync widths and frame length
        n = 0; hs_n = 0; hs_start = -1; hb_n = 0; vs_n = 0; vs_start = -1; max_v = 0;
        while (n < 1344 * 806 + 16) begin
            @(negedge clk);
            n++;
            if (frame_start) break;
            if (vcount == 0) begin
                if (!hsync) begin
                    hs_n++;
                    if (hs_start < 0) hs_start = int'(hcount);
                end
                if (hblnk) hb_n++;
            end
            if (!vsync) begin
                vs_n++;
                if (vs_start < 0) vs_start = int'(vcount);
            end
            if (int'(vcount) > max_v) max_v = int'(vcount);
        end
        chk("first_frame_start_cycles", n, 1344 * 806);
        chk("m0_hsync_low_cycles", hs_n, 136);
        chk("m0_hsync_start_h", hs_start, 1048);
        chk("m0_hblnk_cycles", hb_n, 320);
        chk("m0_vsync_low_cycles", vs_n, 8064);
        chk("m0_vsync_start_v", vs_start, 771);
        chk("m0_lines", max_v + 1, 806);

        // request mode 1 mid-frame; it must only take effect at the frame boundary
        wait_v(100, 1344 * 200);
        mode_sel = 1'b1;
        n = 0; bad = 0;
        while (n < 1344 * 806) begin
            @(negedge clk);
            n++;
            if (frame_start) break;
            if (mode_act) bad++;
        end
        chk("m0_held_cycles_in_mode1", bad, 0);
        chk("switch_frame_start", frame_start, 1);
        chk("mode_act_after_switch", mode_act, 1);

        // mode-1 frame
        n = 0; hs_n = 0; hs_start = -1; max_v = 0; max_h = 0;
        while (n < 1056 * 628 + 16) begin
            @(negedge clk);
            n++;
            if (frame_start) break;
            if (vcount == 0 && hsync) begin
                hs_n++;
                if (hs_start < 0) hs_start = int'(hcount);
            end
            if (int'(vcount) > max_v) max_v = int'(vcount);
            if (int'(hcount) > max_h) max_h = int'(hcount);
        end
        chk("m1_frame_cycles", n, 1056 * 628);
        chk("m1_hsync_high_cycles", hs_n, 128);
        chk("m1_hsync_start_h", hs_start, 840);
        chk("m1_htotal", max_h + 1, 1056);
        chk("m1_lines", max_v + 1, 628);
        @(negedge clk);
        chk("frame_cnt_after_3", frame_cnt, (FCNT_EN != 0) ? 3 : 0);
        chk("frame_start_pulses", n_fs, 3);

        // asynchronous reset in the middle of a frame
        wait_v(400, 1056 * 450);
        rst = 1'b1;
        #1;
        chk("async_rst_hcount", hcount, 0);
        chk("async_rst_vcount", vcount, 0);
        chk("async_rst_mode_act", mode_act, 0);
        chk("async_rst_frame_cnt", frame_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hs_start = -1;
        for (int i = 0; i < 1344; i++) begin
            @(negedge clk);
            if (!hsync && hs_start < 0) hs_start = int'(hcount);
        end
        chk("post_rst_hsync_start_h", hs_start, 1048);
        chk("post_rst_hcount_wrap", hcount, 0);
        chk("post_rst_vcount", vcount, 1);
        chk("post_rst_mode_act", mode_act, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_multi.md
VGA_TIMING_MULTI -- requirements
Module: vga_timing_multi

Interface
REQ-001 SHALL have parameter CNT_W, default 11: width of hcount/vcount; must hold every total in the mode table.
REQ-002 SHALL have parameter FRM_W, default 16: width of frame_cnt.
REQ-003 SHALL have port clk, input, 1: pixel clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port mode_sel, input, 1: requested mode; 0 = 1024x768, 1 = 800x600.
REQ-006 SHALL have port mode_act, output, 1: mode currently being generated.
REQ-007 SHALL have ports hcount and vcount, output, CNT_W: current pixel column and line.
REQ-008 SHALL have ports hsync and vsync, output, 1: sync pulses at the active mode's polarity.
REQ-009 SHALL have ports hblnk, vblnk and de, output, 1: horizontal blank, vertical blank, and de = !hblnk && !vblnk.
REQ-010 SHALL have port frame_start, output, 1: one-cycle pulse while hcount==0 and vcount==0.
REQ-011 SHALL have port frame_cnt, output, FRM_W: frame counter (see REQ-024).

Function
REQ-012 SHALL run hcount from 0 to HTOTAL-1 of the active mode, then wrap to 0.
REQ-013 SHALL increment vcount only on an hcount wrap, and wrap vcount from VTOTAL-1 to 0.
REQ-014 SHALL register every output so that all outputs describe the same (hcount, vcount) on the same cycle; there is no relative skew between outputs.
REQ-015 SHALL assert hblnk while hcount >= HACTIVE, and vblnk while vcount >= VACTIVE.
REQ-016 SHALL define the horizontal sync window as HACTIVE+HFP <= hcount < HACTIVE+HFP+HSYNC, and the vertical window analogously from vcount.
REQ-017 SHALL drive each sync to the active level inside its window and to the inverse level outside it; a negative polarity mode has active level 0.
REQ-018 SHALL sample mode_sel only on the last pixel of a frame (hcount==HTOTAL-1 and vcount==VTOTAL-1), and apply the sampled mode from the next pixel (0,0).
REQ-019 SHALL ignore mode_sel changes at all other times, so that no frame is ever generated with mixed timings.
REQ-020 SHALL implement mode 0 as H 1024/24/136/160 (total 1344), V 768/3/6/29 (total 806), with negative hsync and negative vsync.
REQ-021 SHALL implement mode 1 as H 800/40/128/88 (total 1056), V 600/1/4/23 (total 628), with positive hsync and positive vsync.

Reset
REQ-022 SHALL, while rst is high, hold hcount=0, vcount=0, mode_act=0, frame_cnt=0, hblnk=0, vblnk=0, de=1, frame_start=0, with hsync and vsync at the mode-0 inactive level (1).
REQ-023 SHALL begin counting on the first rising edge after rst deasserts; an assertion mid-frame aborts the frame immediately, with no pending mode change retained.

Configuration
REQ-024 SHALL, with VGA_TIMING_FRAME_CNT_EN defined, increment frame_cnt on each frame wrap, wrap modulo 2^FRM_W, and update it on the same cycle frame_start asserts.
REQ-025 SHALL, without VGA_TIMING_FRAME_CNT_EN, keep the frame_cnt port, tie it to 0, and synthesise no counter logic.

Structure
REQ-026 SHALL place the vga_mode_t struct (active, front porch, sync and back porch for H and V, plus the two polarity bits) and the MODE_1024x768 and MODE_800x600 constants in vga_pkg.
REQ-027 SHALL use a single sub-module, vga_sync_gen: a combinational comparator mapping (count, mode fields) to blank, sync and de, instantiated once for H and once for V.

Verification
REQ-028 SHALL verify reset: rst high for 2 cycles, mode_sel=0 -> hcount=0, vcount=0, hsync=vsync=1, frame_cnt=0; the first frame_start appears 1344*806 cycles after release.
REQ-029 SHALL verify mode-0 horizontal timing: free run -> hsync low for exactly 136 cycles, starting at hcount 1048; hblnk high for 320 cycles per 1344.
REQ-030 SHALL verify mode-0 vertical timing: free run -> vsync low for 6 lines (8064 cycles), starting at vcount 771; 806 lines per frame.
REQ-031 SHALL verify a mid-frame switch: mode_sel 0->1 at vcount=100 -> mode_act stays 0 to the frame end; the next frame has total 1056x628, hsync high at hcount 840..967.
REQ-032 SHALL verify reset mid-frame: rst asserted at vcount=400 -> counters return to 0 asynchronously; after release, mode 0 timing restarts from (0,0).
REQ-033 SHALL verify the frame counter, with VGA_TIMING_FRAME_CNT_EN defined: 3 frames -> frame_cnt=3, with exactly 3 single-cycle frame_start pulses.
